// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the arbitrated 64-bit adder.
// Pipeline register layouts plus the signed-overflow helper.
package adder_arb_pkg;

  localparam int WIDTH    = 64;
  localparam int NREQ_MAX = 8;

  typedef logic [63:0] word_t;

  typedef struct {
    word_t      a;
    word_t      b;
    logic [2:0] id;
  } s0_t;

  typedef struct {
    word_t      sum;
    logic       ovf;
    logic [2:0] id;
  } s1_t;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic signed_ovf(input word_t a, input word_t b, input word_t s);
    return (a[63] == b[63]) && (s[63] != a[63]);
  endfunction

endpackage

// File: rtl/fullAdder_64.sv
// 64-bit ripple-carry adder; carry out of the top bit is dropped.
module fullAdder_64 (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  output logic [63:0] o_sum
);

  logic [63:0] w_carry;

  assign w_carry[0] = 1'b0;

  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry[i];
    if (i < 63) begin : g_carry
      assign w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// The grant vector is suppressed when the pipeline cannot advance.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           adv,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] gid
);

  logic w_found;
  int   w_idx;

  always_comb begin
    grant   = '0;
    gid     = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        gid     = IDW'(w_idx);
      end
    end
    if (w_found && adv) grant[gid] = 1'b1;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one ripple adder among NREQ requesters: round-robin grant into S0,
// adder between S0 and S1, S1 drives an in-order tagged response channel.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [IDW-1:0]              rsp_id,
  output logic [WIDTH-1:0]            rsp_sum,
  output logic                        rsp_ovf
);

  s0_t            r_s0;
  s1_t            r_s1;
  logic           r_s0_valid;
  logic           r_s1_valid;
  logic [IDW-1:0] r_rr_ptr;

  logic            w_s1_en;
  logic            w_s0_en;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gid;
  word_t           w_sum;

  assign w_s1_en = !r_s1_valid || rsp_ready;
  assign w_s0_en = !r_s0_valid || w_s1_en;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .adv   (w_s0_en),
    .grant (w_grant),
    .gid   (w_gid)
  );

  fullAdder_64 u_add (
    .i_a   (r_s0.a),
    .i_b   (r_s0.b),
    .o_sum (w_sum)
  );

  // Grant is already gated by S0 advance, so it doubles as the accept strobe.
  assign req_ready = w_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
      r_rr_ptr   <= '0;
      r_s0.a     <= '0;
      r_s0.b     <= '0;
      r_s0.id    <= '0;
      r_s1.sum   <= '0;
      r_s1.ovf   <= 1'b0;
      r_s1.id    <= '0;
    end else begin
      if (w_s1_en) begin
        r_s1_valid <= r_s0_valid;
        r_s1.sum   <= w_sum;
        r_s1.ovf   <= signed_ovf(r_s0.a, r_s0.b, w_sum);
        r_s1.id    <= r_s0.id;
      end
      if (w_s0_en) begin
        r_s0_valid <= |w_grant;
        if (|w_grant) begin
          r_s0.a   <= req_a[w_gid];
          r_s0.b   <= req_b[w_gid];
          r_s0.id  <= 3'(w_gid);
          r_rr_ptr <= (int'(w_gid) == NREQ - 1) ? '0 : w_gid + 1'b1;
        end
      end
    end
  end

  assign rsp_valid = r_s1_valid;
  assign rsp_sum   = r_s1.sum;
  assign rsp_ovf   = r_s1.ovf;
  assign rsp_id    = IDW'(r_s1.id);

endmodule

// File: tb/tb_adder_arbiter.sv
// Scenario bench for adder_arbiter: accepts push expected sums into a queue,
// responses pop and compare; each scenario task also checks its own timing.
module tb_adder_arbiter;

  localparam int NREQ = 4;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] sum;
    logic        ovf;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][63:0]  req_a;
  logic [NREQ-1:0][63:0]  req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_id;
  logic [63:0]            rsp_sum;
  logic                   rsp_ovf;

  int   checks   = 0;
  int   failures = 0;
  int   n_rsp    = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf)
  );

  // Inputs change at posedge+1, so the negedge view equals what the next edge sees.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got id=%0d sum=%h with nothing outstanding", rsp_id, rsp_sum);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (rsp_id !== e.id || rsp_sum !== e.sum || rsp_ovf !== e.ovf) begin
            failures++;
            $display("FAIL sb_rsp: got id=%0d sum=%h ovf=%b, want id=%0d sum=%h ovf=%b",
                     rsp_id, rsp_sum, rsp_ovf, e.id, e.sum, e.ovf);
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          e.id  = 2'(i);
          e.sum = req_a[i] + req_b[i];
          e.ovf = (req_a[i][63] == req_b[i][63]) && (e.sum[63] != req_a[i][63]);
          q.push_back(e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (n) cyc();
  endtask

  task automatic test_reset();
    do_reset();
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 64'd0 ||
          rsp_ovf !== 1'b0 || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL reset_idle: cycle %0d got valid=%b id=%0d sum=%h ovf=%b ready=%b, want all zero",
                 c, rsp_valid, rsp_id, rsp_sum, rsp_ovf, req_ready);
      end
    end
    // Fill both stages while stalled, then reset: nothing may come out.
    cyc();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    req_a[1]  = 64'd11;
    req_b[1]  = 64'd22;
    cyc();
    cyc();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_fill: got ready=%b rsp_valid=%b, want ready=0000 rsp_valid=1", req_ready, rsp_valid);
    end
    reset     = 1'b1;
    req_valid = '0;
    cyc();
    reset     = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_flush: cycle %0d got rsp_valid=%b, want 0", c, rsp_valid);
      end
    end
    cyc();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 64'(i + 1);
      req_b[i] = 64'(i * 2);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_ptr: got ready=%b, want 0001", req_ready);
    end
    cyc();
    drain(4);
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_a[2]  = 64'd5;
    req_b[2]  = 64'd7;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready: got %b, want 0100", req_ready);
    end
    cyc();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early: got rsp_valid=%b one edge after accept, want 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 64'd12 || rsp_ovf !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: got valid=%b id=%0d sum=%0d ovf=%b, want 1/2/12/0",
               rsp_valid, rsp_id, rsp_sum, rsp_ovf);
    end
    drain(3);
  endtask

  task automatic test_round_robin();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 64'(i * 1000 + 1);
      req_b[i] = 64'(i);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      logic [3:0] want;
      want = 4'b0001 << (k % 4);
      @(negedge clk);
      checks++;
      if (req_ready !== want) begin
        failures++;
        $display("FAIL rr_grant: step %0d got %b, want %b", k, req_ready, want);
      end
      if (k >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1) begin
          failures++;
          $display("FAIL rr_rate: step %0d got rsp_valid=%b, want 1", k, rsp_valid);
        end
      end
      cyc();
    end
    drain(4);
  endtask

  task automatic test_backpressure();
    int k;
    int acc_cnt;
    int base;
    int budget;
    logic acc;
    do_reset();
    rsp_ready = 1'b0;
    k         = 0;
    acc_cnt   = 0;
    base      = n_rsp;
    req_valid = 4'b0010;
    req_a[1]  = 64'h1000;
    req_b[1]  = 64'd0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = req_valid[1] && req_ready[1];
      if (c >= 3) begin
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd1 ||
            rsp_sum !== 64'h1000) begin
          failures++;
          $display("FAIL bp_hold: cycle %0d got ready=%b valid=%b id=%0d sum=%h, want 0000/1/1/1000",
                   c, req_ready, rsp_valid, rsp_id, rsp_sum);
        end
      end
      cyc();
      if (acc) begin
        k++;
        acc_cnt++;
        req_a[1] = 64'h1000 + 64'(k);
        req_b[1] = 64'(k * 3);
      end
    end
    checks++;
    if (acc_cnt != 2) begin
      failures++;
      $display("FAIL bp_accepts: got %0d accepted while stalled, want 2", acc_cnt);
    end
    rsp_ready = 1'b1;
    budget    = 0;
    while ((k < 4 || q.size() != 0) && budget < 30) begin
      @(negedge clk);
      acc = req_valid[1] && req_ready[1];
      cyc();
      if (acc) begin
        k++;
        req_a[1] = 64'h1000 + 64'(k);
        req_b[1] = 64'(k * 3);
      end
      if (k == 4) req_valid = '0;
      budget++;
    end
    checks++;
    if (k != 4 || (n_rsp - base) != 4 || q.size() != 0) begin
      failures++;
      $display("FAIL bp_drain: got accepted=%0d responses=%0d outstanding=%0d, want 4/4/0",
               k, n_rsp - base, q.size());
    end
    drain(2);
  endtask

  task automatic test_overflow();
    logic [63:0] a_v [2];
    logic [63:0] s_v [2];
    logic        o_v [2];
    a_v[0] = 64'h7FFF_FFFF_FFFF_FFFF; s_v[0] = 64'h8000_0000_0000_0000; o_v[0] = 1'b1;
    a_v[1] = 64'hFFFF_FFFF_FFFF_FFFF; s_v[1] = 64'h0;                   o_v[1] = 1'b0;
    do_reset();
    rsp_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      req_valid = 4'b0001;
      req_a[0]  = a_v[t];
      req_b[0]  = 64'd1;
      cyc();
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== s_v[t] || rsp_ovf !== o_v[t]) begin
        failures++;
        $display("FAIL ovf_case%0d: got valid=%b id=%0d sum=%h ovf=%b, want 1/0/%h/%b",
                 t, rsp_valid, rsp_id, rsp_sum, rsp_ovf, s_v[t], o_v[t]);
      end
      cyc();
    end
    drain(3);
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 64'(40 + i);
      req_b[i] = 64'(i);
    end
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_g3: got %b, want 1000", req_ready);
    end
    cyc();
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_g0: got %b, want 0001", req_ready);
    end
    cyc();
    req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_ptr1: got %b, want 0010", req_ready);
    end
    cyc();
    drain(4);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_ptr_wrap();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d outstanding results, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
